// File: rtl/tt_asiclab_pkg.sv
// Shared definitions for the sum-and-transmit UART block: FSM state encoding
// and the default bit period.
package tt_asiclab_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned BAUD_W               = 8;

endpackage

// File: rtl/asiclab_uart_tx_core.sv
// 8N1 serializer: start bit, 8 data bits LSB first, one stop bit, each held
// for CLKS_PER_BIT cycles. tx/busy/done are registered outputs.
module asiclab_uart_tx_core
  import tt_asiclab_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       idle_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_done;

  assign bit_done = (state_q != IDLE) && (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && bit_idx_q == 3'd7) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is computed from the next state so the line changes on the same edge
  // as the state, keeping every output a plain flop.
  always_comb begin
    baud_d    = (state_q == IDLE || bit_done) ? '0 : baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (state_q == IDLE) begin
      bit_idx_d = '0;
      if (start_i) shift_d = data_i;
    end else if (state_q == DATA && bit_done) begin
      bit_idx_d = bit_idx_q + 1'b1;
      shift_d   = shift_q >> 1;
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && bit_done;
  end

  assign idle_o = (state_q == IDLE);
  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/tt_um_asiclab_sum_uart_tx.sv
// Adds the two nibbles of ui_in on a start edge and transmits the 5-bit sum
// as one UART byte; the sum stays visible on uo_out[7:3].
module tt_um_asiclab_sum_uart_tx
  import tt_asiclab_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       start_q;
  logic [4:0] sum_q, sum_d;
  logic [4:0] sum_calc;
  logic       start_ev, accept;
  logic       core_idle, core_tx, core_busy, core_done;
  logic       unused_ok;

  // start_q resets high so a request held through reset needs a fresh rise.
  assign start_ev = uio_in[0] & ~start_q;
  assign accept   = start_ev & core_idle;
  assign sum_calc = {1'b0, ui_in[7:4]} + {1'b0, ui_in[3:0]};
  assign sum_d    = accept ? sum_calc : sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= 1'b1;
      sum_q   <= '0;
    end else begin
      start_q <= uio_in[0];
      sum_q   <= sum_d;
    end
  end

  asiclab_uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(accept),
    .data_i ({3'b000, sum_calc}),
    .idle_o (core_idle),
    .tx_o   (core_tx),
    .busy_o (core_busy),
    .done_o (core_done)
  );

  assign uo_out    = {sum_q, core_done, core_busy, core_tx};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_asiclab_sum_uart_tx.sv
// Directed bench for the sum UART transmitter at 16 clocks per bit.
module tb_tt_um_asiclab_sum_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tt_um_asiclab_sum_uart_tx #(.CLKS_PER_BIT(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    logic [7:0] ui;
    logic [4:0] exp_sum;
    logic [7:0] exp_byte;
    int         mode;  // 0 plain, 1 start held, 2 disturbed, 3 coincident edge, 4 edge after STOP
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts a frame and samples at the negedge after edge E0+k.
  task automatic run_frame(input vec_t v);
    logic exp_tx;
    @(negedge clk);
    uio_in = 8'h00;
    ui_in  = v.ui;
    @(negedge clk);
    uio_in = 8'h01;
    @(posedge clk);
    for (int k = 0; k <= 161; k++) begin
      @(negedge clk);
      if (v.mode != 1 && k == 0) uio_in = 8'h00;
      if (v.mode == 2) begin
        if (k == 49) uio_in = 8'h01;
        if (k == 52) uio_in = 8'h00;
        if (k == 60) ui_in = ~v.ui;
      end
      if (v.mode == 3 && k == 159) uio_in = 8'h01;
      if (v.mode == 4 && k == 160) uio_in = 8'h01;
      if (k % 16 == 8 && k < 160) begin
        if (k < 16)       exp_tx = 1'b0;
        else if (k < 144) exp_tx = v.exp_byte[(k - 16) / 16];
        else              exp_tx = 1'b1;
        check($sformatf("tx ui=%h k=%0d", v.ui, k), {7'b0, uo_out[0]}, {7'b0, exp_tx});
      end
      if (k == 8)   check($sformatf("busy ui=%h", v.ui), {7'b0, uo_out[1]}, 8'h01);
      if (k == 8 || k == 100)
        check($sformatf("sum ui=%h k=%0d", v.ui, k), {3'b0, uo_out[7:3]}, {3'b0, v.exp_sum});
      if (k == 159) check($sformatf("done early ui=%h", v.ui), {7'b0, uo_out[2]}, 8'h00);
      if (k == 160) check($sformatf("done/busy/tx ui=%h", v.ui), {5'b0, uo_out[2:0]}, 8'h05);
      if (k == 161) begin
        check($sformatf("done width ui=%h", v.ui), {7'b0, uo_out[2]}, 8'h00);
        if (v.mode == 4) check("accept after STOP", {6'b0, uo_out[1:0]}, 8'h02);
        else             check($sformatf("idle after ui=%h", v.ui), {6'b0, uo_out[1:0]}, 8'h01);
      end
    end
    if (v.mode == 1) begin
      for (int k = 0; k < 340; k++) @(negedge clk);
      check("held start single frame", {6'b0, uo_out[1:0]}, 8'h01);
    end
    uio_in = 8'h00;
    if (v.mode == 4) begin
      for (int k = 0; k < 170; k++) @(negedge clk);
      check("second frame finished", {6'b0, uo_out[1:0]}, 8'h01);
    end
    $display("frame ui=%h mode=%0d sum=%0d done", v.ui, v.mode, v.exp_sum);
  endtask

  initial begin
    bit busy_seen;
    bit done_seen;
    vecs[0] = '{8'h35, 5'd8,  8'h08, 0};
    vecs[1] = '{8'hFF, 5'd30, 8'h1E, 0};
    vecs[2] = '{8'h00, 5'd0,  8'h00, 0};
    vecs[3] = '{8'h9A, 5'd19, 8'h13, 0};
    vecs[4] = '{8'hF1, 5'd16, 8'h10, 1};
    vecs[5] = '{8'h0F, 5'd15, 8'h0F, 2};
    vecs[6] = '{8'h72, 5'd9,  8'h09, 3};
    vecs[7] = '{8'h44, 5'd8,  8'h08, 4};

    ena    = 1'b1;
    ui_in  = 8'h35;
    uio_in = 8'h01;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset uo_out", uo_out, 8'h01);
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
    $display("reset with start held: uo_out=%h", uo_out);

    // Start held across reset release must not launch a frame.
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (uo_out[1]) busy_seen = 1'b1;
    end
    check("no frame from held start", {7'b0, busy_seen}, 8'h00);
    $display("held start after reset: busy_seen=%0d", busy_seen);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Reset one cycle at cycle 70 of a frame aborts it without a done pulse.
    @(negedge clk);
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    @(posedge clk);
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk);
      if (k == 0)  uio_in = 8'h00;
      if (k == 69) rst_n = 1'b0;
    end
    check("abort tx/busy/done", {5'b0, uo_out[2:0]}, 8'h01);
    check("abort sum", {3'b0, uo_out[7:3]}, 8'h00);
    rst_n = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (uo_out[2]) done_seen = 1'b1;
      if (uo_out[1]) busy_seen = 1'b1;
    end
    check("abort no done", {7'b0, done_seen}, 8'h00);
    check("abort stays idle", {7'b0, busy_seen}, 8'h00);
    $display("mid-frame reset: done_seen=%0d busy_seen=%0d", done_seen, busy_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
